// File: rtl/inst_fetch.sv
// inst_fetch: fetches 16-bit little-endian instruction words from byte-wide
// program memory. Optional prefetch buffer: define INST_FETCH_PREFETCH_EN.
module inst_fetch #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic                mem_req_out,
  output logic [PC_WIDTH:0]   mem_addr_out,
  input  logic                mem_ack_in,
  input  logic [7:0]          mem_data_in,
  output logic [15:0]         inst_out,
  output logic                inst_valid_out,
  input  logic                inst_ready_in,
  output logic [PC_WIDTH-1:0] pc_out,
  input  logic                redirect_in,
  input  logic [PC_WIDTH-1:0] redirect_pc_in
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH:0]   addr_q, addr_d;
  logic [7:0]          lo_q, lo_d;
  logic [15:0]         inst_q, inst_d;
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] fpc;

  assign fpc = pc_q + 1'b1;

`ifdef INST_FETCH_PREFETCH_EN
  logic [15:0]         buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic                pf_hi_q, pf_hi_d;
  logic [PC_WIDTH-1:0] fpc2;

  assign fpc2 = pc_q + PC_WIDTH'(2);

  assign mem_req_out = (state_q == FETCH_LO) || (state_q == FETCH_HI) ||
                       ((state_q == HOLD) && !buf_full_q);
`else
  assign mem_req_out = (state_q == FETCH_LO) || (state_q == FETCH_HI);
`endif

  assign mem_addr_out   = addr_q;
  assign inst_out       = inst_q;
  assign inst_valid_out = valid_q;
  assign pc_out         = pc_q;

  // Next-state: byte fetch sequencing, word hand-off, redirect override
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    inst_d  = inst_q;
    valid_d = valid_q;
`ifdef INST_FETCH_PREFETCH_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    pf_hi_d    = pf_hi_q;
`endif
    unique case (state_q)
      IDLE: begin
        state_d = FETCH_LO;
        addr_d  = {pc_q, 1'b0};
      end
      FETCH_LO: begin
        if (mem_ack_in) begin
          lo_d    = mem_data_in;
          state_d = FETCH_HI;
          addr_d  = {pc_q, 1'b1};
        end
      end
      FETCH_HI: begin
        if (mem_ack_in) begin
          inst_d  = {mem_data_in, lo_q};
          valid_d = 1'b1;
          state_d = HOLD;
`ifdef INST_FETCH_PREFETCH_EN
          addr_d     = {fpc, 1'b0};
          pf_hi_d    = 1'b0;
          buf_full_d = 1'b0;
`endif
        end
      end
      HOLD: begin
`ifdef INST_FETCH_PREFETCH_EN
        if (inst_ready_in) begin
          pc_d = fpc;
          if (buf_full_q) begin
            inst_d     = buf_q;
            buf_full_d = 1'b0;
            pf_hi_d    = 1'b0;
            addr_d     = {fpc2, 1'b0};
          end else if (!pf_hi_q) begin
            valid_d = 1'b0;
            if (mem_ack_in) begin
              lo_d    = mem_data_in;
              state_d = FETCH_HI;
              addr_d  = {fpc, 1'b1};
            end else begin
              state_d = FETCH_LO;
            end
          end else if (mem_ack_in) begin
            // Word completes as the old one leaves: straight to inst_out
            inst_d  = {mem_data_in, lo_q};
            addr_d  = {fpc2, 1'b0};
            pf_hi_d = 1'b0;
          end else begin
            valid_d = 1'b0;
            state_d = FETCH_HI;
          end
        end else if (!buf_full_q && mem_ack_in) begin
          if (!pf_hi_q) begin
            lo_d    = mem_data_in;
            pf_hi_d = 1'b1;
            addr_d  = {fpc, 1'b1};
          end else begin
            buf_d      = {mem_data_in, lo_q};
            buf_full_d = 1'b1;
          end
        end
`else
        if (inst_ready_in) begin
          pc_d    = fpc;
          valid_d = 1'b0;
          state_d = FETCH_LO;
          addr_d  = {fpc, 1'b0};
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (redirect_in) begin
      state_d = IDLE;
      pc_d    = redirect_pc_in;
      addr_d  = addr_q;
      inst_d  = inst_q;
      valid_d = 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      buf_full_d = 1'b0;
      pf_hi_d    = 1'b0;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      lo_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

`ifdef INST_FETCH_PREFETCH_EN
  // Prefetch buffer registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      pf_hi_q    <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      pf_hi_q    <= pf_hi_d;
    end
  end
`endif

endmodule
